seq_stream_gen: RTL and testbench

- Drives the `sequence_in` side of the sequence interface, the transmit end feeding the sequence detector.
- Accepts parallel words of 1..WIDTH bits through a valid/ready handshake and serializes them MSB-first, one bit per clock.
- Consecutive words are emitted back-to-back with no gap, using a one-entry holding register.
- Provides word-done and busy status for the test controller, plus an optional self-check counter of emitted 1011 patterns.

---
 rtl/seq_stream_gen.sv | 181 ++++++++++++++++++
 tb/tb_seq_stream_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_gen.sv
// seq_stream_gen: serializes 1..WIDTH-bit words MSB-first onto sequence_out.
// Optional 1011 self-check counter enabled by SEQ_STREAM_GEN_SELFCHECK_EN.
//
// Ports:
//   clock, reset        : rising-edge clock, async active-low reset
//   load_valid/ready    : word handshake (ready = holding register empty)
//   load_data/load_len  : word and bit count (0 or >WIDTH means WIDTH)
//   sequence_out        : registered serial bit
//   out_valid           : sequence_out carries a live bit
//   word_done           : pulse with the last bit of each word
//   busy                : shifter or holding register occupied
//   match_count         : overlapping 1011 count (0 when feature disabled)

module seq_stream_gen #(
    parameter int WIDTH = 8,
    parameter int LENW  = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LENW-1:0]  load_len,
    output logic             sequence_out,
    output logic             out_valid,
    output logic             word_done,
    output logic             busy,
    output logic [15:0]      match_count
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam logic [LENW-1:0] LEN_MAX = LENW'(WIDTH);
    localparam logic [LENW-1:0] LEN_ONE = LENW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [LENW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic [LENW-1:0]  hold_len_q, hold_len_d;
    logic             hold_full_q, hold_full_d;
    logic             seq_q, seq_d;
    logic             ov_q, ov_d;
    logic             wd_q, wd_d;

    logic             xfer;
    logic             last_bit;
    logic [LENW-1:0]  in_len;
    logic [LENW-1:0]  in_pad;
    logic [WIDTH-1:0] in_aligned;

    // Length decode: out-of-range lengths fall back to a full word.
    always_comb begin
        in_len = load_len;
        if (load_len == '0 || load_len > LEN_MAX) begin
            in_len = LEN_MAX;
        end
    end

    // Words are left-aligned on entry so the shifter always emits its MSB.
    assign in_pad     = LEN_MAX - in_len;
    assign in_aligned = load_data << in_pad;

    assign load_ready = !hold_full_q;
    assign xfer       = load_valid && load_ready;
    assign last_bit   = (state_q == SHIFT) && (cnt_q == LEN_ONE);

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_len_d  = hold_len_q;
        hold_full_d = hold_full_q;
        seq_d       = 1'b0;
        ov_d        = 1'b0;
        wd_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    sh_d    = in_aligned;
                    cnt_d   = in_len;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                seq_d = sh_q[WIDTH-1];
                ov_d  = 1'b1;
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - LEN_ONE;
                if (last_bit) begin
                    wd_d = 1'b1;
                    // Next word enters the shifter at this edge: no bubble.
                    if (hold_full_q) begin
                        sh_d        = hold_data_q;
                        cnt_d       = hold_len_q;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        sh_d  = in_aligned;
                        cnt_d = in_len;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    hold_data_d = in_aligned;
                    hold_len_d  = in_len;
                    hold_full_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_len_q  <= '0;
            hold_full_q <= 1'b0;
            seq_q       <= 1'b0;
            ov_q        <= 1'b0;
            wd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_len_q  <= hold_len_d;
            hold_full_q <= hold_full_d;
            seq_q       <= seq_d;
            ov_q        <= ov_d;
            wd_q        <= wd_d;
        end
    end

    assign sequence_out = seq_q;
    assign out_valid    = ov_q;
    assign word_done    = wd_q;
    assign busy         = (state_q == SHIFT) || hold_full_q;

`ifdef SEQ_STREAM_GEN_SELFCHECK_EN
    logic [3:0]  hist_q, hist_d;
    logic [15:0] mc_q, mc_d;

    // History advances together with the bit being registered for output,
    // so the count tracks the emitted stream; idle cycles leave it alone.
    always_comb begin
        hist_d = hist_q;
        mc_d   = mc_q;
        if (state_q == SHIFT) begin
            hist_d = {hist_q[2:0], sh_q[WIDTH-1]};
            if (hist_d == 4'b1011 && mc_q != 16'hFFFF) begin
                mc_d = mc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            mc_q   <= '0;
        end else begin
            hist_q <= hist_d;
            mc_q   <= mc_d;
        end
    end

    assign match_count = mc_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_stream_gen.sv
// tb_seq_stream_gen: directed table and sequence checks for seq_stream_gen.
// Expected bit streams are hand-computed in the vector table and sequences.

module tb_seq_stream_gen;

    logic        clock;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_data;
    logic [3:0]  load_len;
    logic        sequence_out;
    logic        out_valid;
    logic        word_done;
    logic        busy;
    logic [15:0] match_count;

`ifdef SEQ_STREAM_GEN_SELFCHECK_EN
    localparam int MC_B2B = 2;
`else
    localparam int MC_B2B = 0;
`endif

    int checks;
    int failures;

    seq_stream_gen #(.WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_len    (load_len),
        .sequence_out(sequence_out),
        .out_valid   (out_valid),
        .word_done   (word_done),
        .busy        (busy),
        .match_count (match_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [3:0] len;
        logic [7:0] exp_bits;
        int         exp_n;
    } vec_t;

    vec_t vecs[7];

    // stream-sequence inputs and captured results
    logic [7:0]  sw_d[3];
    logic [3:0]  sw_l[3];
    int          sw_n;
    logic [31:0] st_bits;
    logic [31:0] st_wd;
    logic [15:0] st_rdy;
    int          st_nb;
    int          st_first;
    int          st_last;
    int          acc[3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        load_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic send_and_check(input vec_t v);
        wait_idle();
        chk({v.name, "_ready"}, 32'(load_ready), 32'd1);
        load_data  = v.data;
        load_len   = v.len;
        load_valid = 1'b1;
        @(posedge clock);
        #1;
        load_valid = 1'b0;
        chk({v.name, "_lat"}, 32'(out_valid), 32'd0);
        for (int i = 0; i < v.exp_n; i++) begin
            @(posedge clock);
            #1;
            chk({v.name, "_valid"}, 32'(out_valid), 32'd1);
            chk({v.name, "_bit"}, 32'(sequence_out),
                32'(v.exp_bits[v.exp_n-1-i]));
            chk({v.name, "_done"}, 32'(word_done),
                32'(i == v.exp_n - 1));
        end
        @(posedge clock);
        #1;
        chk({v.name, "_end_valid"}, 32'(out_valid), 32'd0);
        chk({v.name, "_end_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_stream(input int cycles);
        int   widx;
        logic xfer;
        st_bits  = '0;
        st_wd    = '0;
        st_rdy   = '0;
        st_nb    = 0;
        st_first = -1;
        st_last  = -1;
        for (int i = 0; i < 3; i++) acc[i] = -1;
        widx       = 0;
        load_data  = sw_d[0];
        load_len   = sw_l[0];
        load_valid = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            xfer = load_valid && load_ready;
            @(posedge clock);
            #1;
            if (xfer) begin
                acc[widx] = c;
                widx++;
                if (widx < sw_n) begin
                    load_data = sw_d[widx];
                    load_len  = sw_l[widx];
                end else begin
                    load_valid = 1'b0;
                end
            end
            if (c < 16) st_rdy[c] = load_ready;
            if (out_valid) begin
                st_bits = {st_bits[30:0], sequence_out};
                st_wd   = {st_wd[30:0], word_done};
                st_nb++;
                if (st_first < 0) st_first = c;
                st_last = c;
            end
        end
        load_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;

        vecs[0] = '{"v_b2", 8'b1011_0010, 4'd8, 8'b1011_0010, 8};
        vecs[1] = '{"v_len0", 8'hA5, 4'd0, 8'b1010_0101, 8};
        vecs[2] = '{"v_len1", 8'h01, 4'd1, 8'b0000_0001, 1};
        vecs[3] = '{"v_len9", 8'h3C, 4'd9, 8'b0011_1100, 8};
        vecs[4] = '{"v_len3", 8'hFD, 4'd3, 8'b0000_0101, 3};
        vecs[5] = '{"v_len15", 8'h5A, 4'd15, 8'b0101_1010, 8};
        vecs[6] = '{"v_len2", 8'h02, 4'd2, 8'b0000_0010, 2};

        // reset values
        #1;
        chk("rst_seq", 32'(sequence_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(word_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_mc", 32'(match_count), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 7; i++) send_and_check(vecs[i]);

        // reset mid-word with a word holding
        wait_idle();
        load_data  = 8'b1011_0010;
        load_len   = 4'd8;
        load_valid = 1'b1;
        @(posedge clock);
        #1;
        load_data = 8'h0F;
        @(posedge clock);
        #1;
        load_valid = 1'b0;
        chk("mid_hold_ready", 32'(load_ready), 32'd0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        chk("mid_pre_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_async_valid", 32'(out_valid), 32'd0);
        chk("mid_async_done", 32'(word_done), 32'd0);
        chk("mid_async_seq", 32'(sequence_out), 32'd0);
        chk("mid_async_busy", 32'(busy), 32'd0);
        chk("mid_async_ready", 32'(load_ready), 32'd1);
        chk("mid_async_mc", 32'(match_count), 32'd0);
        @(posedge clock);
        #1;
        chk("mid_hold_done", 32'(word_done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rel_busy", 32'(busy), 32'd0);
        chk("mid_rel_ready", 32'(load_ready), 32'd1);
        chk("mid_rel_valid", 32'(out_valid), 32'd0);
        send_and_check('{"v_fresh", 8'h96, 4'd8, 8'b1001_0110, 8});

        // back-to-back 1011 then 011
        do_reset();
        sw_n    = 2;
        sw_d[0] = 8'b0000_1011;
        sw_l[0] = 4'd4;
        sw_d[1] = 8'b0000_0011;
        sw_l[1] = 4'd3;
        sw_d[2] = 8'h00;
        sw_l[2] = 4'd0;
        run_stream(12);
        chk("b2b_acc0", 32'(acc[0]), 32'd0);
        chk("b2b_acc1", 32'(acc[1]), 32'd1);
        chk("b2b_nbits", 32'(st_nb), 32'd7);
        chk("b2b_contig", 32'(st_last - st_first + 1), 32'd7);
        chk("b2b_first", 32'(st_first), 32'd1);
        chk("b2b_bits", st_bits & 32'h7F, 32'b1011011);
        chk("b2b_done", st_wd & 32'h7F, 32'b0001001);
        chk("b2b_ready", 32'(st_rdy[4:0]), 32'b10001);
        chk("b2b_busy", 32'(busy), 32'd0);
        chk("b2b_mc", 32'(match_count), 32'(MC_B2B));

        // back-pressure: three words, valid held high
        sw_n    = 3;
        sw_d[0] = 8'b0000_1100;
        sw_l[0] = 4'd4;
        sw_d[1] = 8'b0000_0101;
        sw_l[1] = 4'd3;
        sw_d[2] = 8'b0000_0001;
        sw_l[2] = 4'd2;
        run_stream(14);
        chk("bp_acc0", 32'(acc[0]), 32'd0);
        chk("bp_acc1", 32'(acc[1]), 32'd1);
        chk("bp_acc2", 32'(acc[2]), 32'd5);
        chk("bp_nbits", 32'(st_nb), 32'd9);
        chk("bp_contig", 32'(st_last - st_first + 1), 32'd9);
        chk("bp_bits", st_bits & 32'h1FF, 32'b110010101);
        chk("bp_done", st_wd & 32'h1FF, 32'b000100101);
        chk("bp_busy", 32'(busy), 32'd0);
        chk("bp_mc", 32'(match_count), 32'(MC_B2B));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
